// File: rtl/mem_pkg.sv
// Main-memory bus types shared by the caches, the memory model and mem_arbiter.
// Arbiter additions: arb_state_t, NUM_MEM_REQ and a grant one-hot helper.
package mem_pkg;

    localparam int unsigned MEM_ADDR_W  = 32;
    localparam int unsigned MEM_DATA_W  = 128;
    localparam int unsigned NUM_MEM_REQ = 2;

    typedef struct packed {
        logic                  Valid;
        logic                  Wen;
        logic [MEM_ADDR_W-1:0] Addr;
        logic [MEM_DATA_W-1:0] WriteD;
    } MInput;

    typedef struct packed {
        logic                  Ready;
        logic [MEM_DATA_W-1:0] ReadD;
    } MOutput;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_t;

    function automatic logic [NUM_MEM_REQ-1:0] owner_onehot(input logic owner);
        logic [NUM_MEM_REQ-1:0] oh;
        oh        = '0;
        oh[owner] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select for mem_arbiter; winner=1 means requester 1.
// MEM_ARB_RR_EN selects strict round-robin, otherwise fixed priority with starvation guard.
module mem_arb_pick
    import mem_pkg::*;
`ifndef MEM_ARB_RR_EN
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
)
`endif
(
    input  logic [NUM_MEM_REQ-1:0] valid,
`ifdef MEM_ARB_RR_EN
    input  logic                   last_q,
`else
    input  logic [CNT_W-1:0]       starve_cnt,
`endif
    output logic                   winner
);

`ifdef MEM_ARB_RR_EN
    always_comb begin
        if (&valid) begin
            winner = !last_q;
        end else begin
            winner = valid[1];
        end
    end
`else
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    // Requester 1 wins unless requester 0 is alone or has waited out the limit.
    always_comb begin
        winner = !(valid[0] && (!valid[1] || (starve_cnt >= LIMIT)));
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the main-memory port between the I-cache (req 0) and the D-cache (req 1).
// Define MEM_ARB_RR_EN for strict round-robin; default is fixed priority with a starvation guard.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  MInput                  req0_i,
    output MOutput                 rsp0_o,
    input  MInput                  req1_i,
    output MOutput                 rsp1_o,
    output MInput                  mem_o,
    input  MOutput                 mem_i,
    output logic [NUM_MEM_REQ-1:0] grant_o
);

    arb_state_t             state_q;
    arb_state_t             state_d;
    logic                   owner_q;
    logic                   owner_d;
    logic                   winner;
    logic                   fwd_ready;
    logic [NUM_MEM_REQ-1:0] valid;
    MInput                  owner_req;

    assign valid     = {req1_i.Valid, req0_i.Valid};
    assign owner_req = owner_q ? req1_i : req0_i;

`ifdef MEM_ARB_RR_EN
    logic last_q;
    logic last_d;

    mem_arb_pick u_pick (
        .valid  (valid),
        .last_q (last_q),
        .winner (winner)
    );
`else
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_d;

    mem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_pick (
        .valid      (valid),
        .starve_cnt (starve_cnt),
        .winner     (winner)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            owner_q    <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_q     <= 1'b1;
`else
            starve_cnt <= '0;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
`ifdef MEM_ARB_RR_EN
            last_q     <= last_d;
`else
            starve_cnt <= starve_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
`ifdef MEM_ARB_RR_EN
        last_d   = last_q;
`else
        starve_d = starve_cnt;
`endif
        unique case (state_q)
            ARB_IDLE: begin
                if (|valid) begin
                    state_d = ARB_BUSY;
                    owner_d = winner;
`ifdef MEM_ARB_RR_EN
                    last_d  = winner;
`endif
                end
`ifndef MEM_ARB_RR_EN
                // A waiting requester 0 always implies a grant this cycle.
                if (!req0_i.Valid || !winner) begin
                    starve_d = '0;
                end else if (starve_cnt < LIMIT) begin
                    starve_d = starve_cnt + 1'b1;
                end
`endif
            end
            ARB_BUSY: begin
                if (mem_i.Ready || !owner_req.Valid) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        mem_o        = '0;
        rsp0_o       = '0;
        rsp1_o       = '0;
        grant_o      = '0;
        fwd_ready    = 1'b0;
        rsp0_o.ReadD = mem_i.ReadD;
        rsp1_o.ReadD = mem_i.ReadD;
        if (state_q == ARB_BUSY) begin
            mem_o        = owner_req;
            grant_o      = owner_onehot(owner_q);
            fwd_ready    = mem_i.Ready && owner_req.Valid;
            rsp0_o.Ready = fwd_ready && !owner_q;
            rsp1_o.Ready = fwd_ready && owner_q;
        end
    end

    grant_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_o));

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: cycle-level reference model, memory model and requester agents.
// Built with the default (fixed priority + starvation guard) configuration.
module tb_mem_arbiter;
    import mem_pkg::*;

    localparam int           LIMIT  = 4;
    localparam logic [127:0] PAT_A5 = 128'hA5;
    localparam logic [127:0] PAT_WR = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    MInput      rq [2];
    MOutput     rsp0;
    MOutput     rsp1;
    MOutput     memr;
    MInput      memq;
    logic [1:0] grant;

    mem_arbiter #(
        .STARVE_LIMIT (LIMIT),
        .CNT_W        (3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0_i  (rq[0]),
        .rsp0_o  (rsp0),
        .req1_i  (rq[1]),
        .rsp1_o  (rsp1),
        .mem_o   (memq),
        .mem_i   (memr),
        .grant_o (grant)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // requester agents
    int           left [2];
    int           start_pct [2];
    int           abort_pct [2];
    bit           fix_en [2];
    logic [31:0]  fix_addr [2];
    bit           fix_wen [2];
    logic [127:0] fix_data [2];
    bit           got [2];

    // memory model
    logic [127:0] memarr [logic [31:0]];
    int           mcnt;
    int           mlat;
    int           fixed_lat;
    int           spur_pct;

    // reference model of the arbiter
    bit m_busy;
    int m_owner;
    int m_waits;

    // observations
    bit           gr_log [$];
    logic [1:0]   prev_grant;
    int           pulses [2];
    logic [127:0] last_rd [2];

    int exp_seq [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    task automatic check_eq(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int glog(input int k);
        if (gr_log.size() > k) return int'(gr_log[k]);
        return 9;
    endfunction

    function automatic logic [127:0] mem_read(input logic [31:0] a);
        if (memarr.exists(a)) return memarr[a];
        return {a, ~a, a ^ 32'h5A5A_5A5A, 32'h0BAD_F00D};
    endfunction

    task automatic start_req(input int i);
        if (left[i] > 0 && int'($urandom_range(99)) < start_pct[i]) begin
            left[i]--;
            rq[i].Valid  = 1'b1;
            rq[i].Wen    = fix_en[i] ? fix_wen[i] : 1'($urandom_range(1));
            rq[i].Addr   = fix_en[i] ? fix_addr[i] : ($urandom & 32'h0000_0FF0);
            rq[i].WriteD = fix_en[i] ? fix_data[i] : {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < 2; i++) begin
            if (rq[i].Valid) begin
                if (got[i]) begin
                    rq[i].Valid = 1'b0;
                    start_req(i);
                end else if (abort_pct[i] > 0 && int'($urandom_range(99)) < abort_pct[i]) begin
                    rq[i].Valid = 1'b0;
                end
            end else begin
                start_req(i);
            end
        end
    endtask

    task automatic mem_step();
        if (memr.Ready) begin
            memr.Ready = 1'b0;
            mcnt       = 0;
        end else if (memq.Valid) begin
            mcnt++;
            if (mcnt == 1) mlat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(4, 1));
            if (mcnt >= mlat) begin
                memr.Ready = 1'b1;
                if (memq.Wen) memarr[memq.Addr] = memq.WriteD;
                else memr.ReadD = mem_read(memq.Addr);
            end
        end else begin
            mcnt = 0;
            if (spur_pct > 0 && int'($urandom_range(99)) < spur_pct) begin
                memr.Ready = 1'b1;
                memr.ReadD = {4{$urandom}};
            end
        end
    endtask

    task automatic check_step();
        MInput own;
        bit    fwd;
        bit    v0;
        bit    v1;
        own = rq[m_owner];
        fwd = m_busy && own.Valid && memr.Ready;
        check_eq("grant", 192'(grant), m_busy ? ((m_owner == 1) ? 192'd2 : 192'd1) : 192'd0);
        if (m_busy) begin
            check_eq("mem_req", 192'(memq), 192'(own));
            check_eq("rdata0", 192'(rsp0.ReadD), 192'(memr.ReadD));
            check_eq("rdata1", 192'(rsp1.ReadD), 192'(memr.ReadD));
        end else begin
            check_eq("idle_valid", 192'(memq.Valid), 192'd0);
            check_eq("idle_wen", 192'(memq.Wen), 192'd0);
        end
        check_eq("ready0", 192'(rsp0.Ready), 192'(fwd && m_owner == 0));
        check_eq("ready1", 192'(rsp1.Ready), 192'(fwd && m_owner == 1));
        got[0] = fwd && m_owner == 0;
        got[1] = fwd && m_owner == 1;

        if (grant != 2'b00 && prev_grant == 2'b00) gr_log.push_back(grant[1]);
        prev_grant = grant;
        if (rsp0.Ready) begin pulses[0]++; last_rd[0] = rsp0.ReadD; end
        if (rsp1.Ready) begin pulses[1]++; last_rd[1] = rsp1.ReadD; end

        // what the arbiter should do at the coming edge
        if (!m_busy) begin
            v0 = rq[0].Valid;
            v1 = rq[1].Valid;
            if (v0 || v1) begin
                m_owner = (v0 && (!v1 || m_waits >= LIMIT)) ? 0 : 1;
                m_busy  = 1'b1;
            end
            if (v0 && m_owner == 1) m_waits = (m_waits + 1 > LIMIT) ? LIMIT : m_waits + 1;
            else m_waits = 0;
        end else if (memr.Ready || !own.Valid) begin
            m_busy = 1'b0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        drive_reqs();
        #1;
        mem_step();
        #1;
        check_step();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic clear_tb();
        for (int i = 0; i < 2; i++) begin
            rq[i]        = '0;
            left[i]      = 0;
            start_pct[i] = 100;
            abort_pct[i] = 0;
            fix_en[i]    = 1'b0;
            fix_addr[i]  = '0;
            fix_wen[i]   = 1'b0;
            fix_data[i]  = '0;
            got[i]       = 1'b0;
        end
        memr       = '0;
        mcnt       = 0;
        mlat       = 1;
        fixed_lat  = 0;
        spur_pct   = 0;
        m_busy     = 1'b0;
        m_owner    = 0;
        m_waits    = 0;
        prev_grant = 2'b00;
    endtask

    task automatic clear_stats();
        gr_log.delete();
        for (int i = 0; i < 2; i++) begin
            pulses[i]  = 0;
            last_rd[i] = '0;
        end
    endtask

    initial begin
        clear_tb();
        clear_stats();

        // reset must override active requests and a memory Ready
        rst_n       = 1'b0;
        rq[0].Valid = 1'b1;
        rq[1].Valid = 1'b1;
        memr.Ready  = 1'b1;
        #12;
        check_eq("rst_grant", 192'(grant), 192'd0);
        check_eq("rst_mvalid", 192'(memq.Valid), 192'd0);
        check_eq("rst_mwen", 192'(memq.Wen), 192'd0);
        check_eq("rst_ready0", 192'(rsp0.Ready), 192'd0);
        check_eq("rst_ready1", 192'(rsp1.Ready), 192'd0);
        clear_tb();
        @(negedge clk);
        rst_n = 1'b1;

        // single read, memory latency 3
        memarr[32'h40] = PAT_A5;
        fixed_lat      = 3;
        fix_en[0]      = 1'b1;
        fix_addr[0]    = 32'h40;
        fix_wen[0]     = 1'b0;
        left[0]        = 1;
        clear_stats();
        run(1);
        check_eq("sr_valid_n", 192'(memq.Valid), 192'd0);
        run(1);
        check_eq("sr_valid_n1", 192'(memq.Valid), 192'd1);
        run(8);
        check_eq("sr_pulses0", 192'(pulses[0]), 192'd1);
        check_eq("sr_data", 192'(last_rd[0]), 192'(PAT_A5));
        check_eq("sr_pulses1", 192'(pulses[1]), 192'd0);
        check_eq("sr_idle", 192'(grant), 192'd0);
        fix_en[0] = 1'b0;
        fixed_lat = 0;

        // contention: both in the same cycle
        clear_stats();
        left[0] = 1;
        left[1] = 1;
        run(20);
        check_eq("cont_len", 192'(gr_log.size()), 192'd2);
        check_eq("cont_first", 192'(glog(0)), 192'd1);
        check_eq("cont_second", 192'(glog(1)), 192'd0);

        // starvation guard: requester 1 continuous, requester 0 held
        clear_stats();
        left[0] = 2;
        left[1] = 1000;
        for (int c = 0; c < 300 && gr_log.size() < 10; c++) cycle();
        check_eq("starve_len", 192'(gr_log.size() >= 10), 192'd1);
        for (int k = 0; k < 10; k++) check_eq($sformatf("starve_seq%0d", k), 192'(glog(k)), 192'(exp_seq[k]));
        left[0] = 0;
        left[1] = 0;
        run(20);

        // write-through from requester 1
        clear_stats();
        fix_en[1]   = 1'b1;
        fix_addr[1] = 32'h104;
        fix_wen[1]  = 1'b1;
        fix_data[1] = PAT_WR;
        left[1]     = 1;
        run(12);
        check_eq("wr_mem", 192'(memarr.exists(32'h104) ? memarr[32'h104] : 128'h0), 192'(PAT_WR));
        check_eq("wr_pulses1", 192'(pulses[1]), 192'd1);
        check_eq("wr_pulses0", 192'(pulses[0]), 192'd0);
        fix_en[1] = 1'b0;

        // memory Ready while idle is ignored
        clear_stats();
        spur_pct = 100;
        run(4);
        spur_pct = 0;
        run(2);
        check_eq("spur_pulses0", 192'(pulses[0]), 192'd0);
        check_eq("spur_pulses1", 192'(pulses[1]), 192'd0);

        // random traffic with aborts and stray Ready pulses
        clear_stats();
        for (int i = 0; i < 2; i++) begin
            left[i]      = 10000;
            start_pct[i] = 30;
            abort_pct[i] = 3;
        end
        spur_pct = 5;
        run(2000);
        for (int i = 0; i < 2; i++) begin
            left[i]      = 0;
            abort_pct[i] = 0;
        end
        spur_pct = 0;
        run(30);
        check_eq("rand_served0", 192'(pulses[0] > 0), 192'd1);
        check_eq("rand_served1", 192'(pulses[1] > 0), 192'd1);
        check_eq("rand_idle", 192'(grant), 192'd0);

        // reset in the middle of a transaction
        for (int i = 0; i < 2; i++) start_pct[i] = 100;
        fixed_lat   = 6;
        fix_en[0]   = 1'b1;
        fix_addr[0] = 32'h40;
        fix_wen[0]  = 1'b0;
        left[0]     = 1;
        run(3);
        memr.Ready = 1'b1;
        #1;
        check_eq("pre_rst_ready0", 192'(rsp0.Ready), 192'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_grant", 192'(grant), 192'd0);
        check_eq("mid_rst_mvalid", 192'(memq.Valid), 192'd0);
        check_eq("mid_rst_ready0", 192'(rsp0.Ready), 192'd0);
        check_eq("mid_rst_ready1", 192'(rsp1.Ready), 192'd0);
        clear_tb();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_stats();
        fixed_lat   = 3;
        fix_en[0]   = 1'b1;
        fix_addr[0] = 32'h40;
        fix_wen[0]  = 1'b0;
        left[0]     = 1;
        run(10);
        check_eq("post_rst_pulses0", 192'(pulses[0]), 192'd1);
        check_eq("post_rst_data", 192'(last_rd[0]), 192'(PAT_A5));
        check_eq("post_rst_pulses1", 192'(pulses[1]), 192'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
